// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: debounced direction buttons step the player through a wall map
// read over a 1-cycle-latency port, with a move pulse per step and a sticky win level.
module maze_move_ctrl #(
   parameter int GRID_W          = 16,
   parameter int GRID_H          = 12,
   parameter int POS_W           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int START_X         = 0,
   parameter int START_Y         = 0,
   parameter int GOAL_X          = 15,
   parameter int GOAL_Y          = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   output logic [POS_W-1:0] wall_x,
   output logic [POS_W-1:0] wall_y,
   input  logic             wall_hit,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output logic             move,
   output logic             win
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [POS_W-1:0] ONE = POS_W'(1);
   localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_W - 1);
   localparam logic [POS_W-1:0] Y_MAX = POS_W'(GRID_H - 1);
   localparam logic [POS_W-1:0] X_START = POS_W'(START_X);
   localparam logic [POS_W-1:0] Y_START = POS_W'(START_Y);
   localparam logic [POS_W-1:0] X_GOAL = POS_W'(GOAL_X);
   localparam logic [POS_W-1:0] Y_GOAL = POS_W'(GOAL_Y);

   typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, WON} state_t;

   state_t state_q, state_d;
   logic [3:0] btn, sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [POS_W-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;
   logic [POS_W-1:0] tgt_x, tgt_y;
   logic tgt_ok, move_q, move_d, win_q, win_d;

   assign btn = {btn_up, btn_down, btn_left, btn_right};
   assign wall_x = wall_x_q;
   assign wall_y = wall_y_q;
   assign pos_x = pos_x_q;
   assign pos_y = pos_y_q;
   assign move = move_q;
   assign win = win_q;

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
            else cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
      press_d = deb_d & ~deb_q;
   end

   // Highest-priority event alone is considered; an out-of-grid target kills the whole event.
   always_comb begin
      tgt_x = pos_x_q;
      tgt_y = pos_y_q;
      tgt_ok = 1'b0;
      if (press_q[3]) begin
         tgt_y = pos_y_q - ONE;
         tgt_ok = pos_y_q != '0;
      end else if (press_q[2]) begin
         tgt_y = pos_y_q + ONE;
         tgt_ok = pos_y_q < Y_MAX;
      end else if (press_q[1]) begin
         tgt_x = pos_x_q - ONE;
         tgt_ok = pos_x_q != '0;
      end else if (press_q[0]) begin
         tgt_x = pos_x_q + ONE;
         tgt_ok = pos_x_q < X_MAX;
      end
   end

   always_comb begin
      state_d = state_q;
      wall_x_d = wall_x_q;
      wall_y_d = wall_y_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      move_d = 1'b0;
      win_d = win_q;
      case (state_q)
         IDLE: begin
            if (tgt_ok) begin
               wall_x_d = tgt_x;
               wall_y_d = tgt_y;
               state_d = LOOKUP;
            end
         end
         LOOKUP: state_d = CHECK;
         CHECK: begin
            state_d = IDLE;
            if (!wall_hit) begin
               pos_x_d = wall_x_q;
               pos_y_d = wall_y_q;
               move_d = 1'b1;
               if (wall_x_q == X_GOAL && wall_y_q == Y_GOAL) begin
                  win_d = 1'b1;
                  state_d = WON;
               end
            end
         end
         default: state_d = WON;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q <= '0;
         press_q <= '0;
         cnt_q <= '{default: '0};
         pos_x_q <= X_START;
         pos_y_q <= Y_START;
         wall_x_q <= X_START;
         wall_y_q <= Y_START;
         move_q <= 1'b0;
         win_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= btn;
         sync2_q <= sync1_q;
         deb_q <= deb_d;
         press_q <= press_d;
         cnt_q <= cnt_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         wall_x_q <= wall_x_d;
         wall_y_q <= wall_y_d;
         move_q <= move_d;
         win_q <= win_d;
      end
   end
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: directed scenarios for maze_move_ctrl with a registered wall-map model.
module tb_maze_move_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [3:0] wall_x, wall_y, pos_x, pos_y;
   logic wall_hit = 1'b0;
   logic move, win;
   logic [191:0] wall_map = '0;
   int total = 0, bad = 0;
   int move_pulses = 0, move_hi = 0, m0 = 0;
   logic move_prev = 1'b0, win_at_move = 1'b0;

   maze_move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .wall_x(wall_x), .wall_y(wall_y), .wall_hit(wall_hit),
      .pos_x(pos_x), .pos_y(pos_y), .move(move), .win(win)
   );

   always #5 clk = ~clk;

   always @(posedge clk) wall_hit <= wall_map[int'(wall_y) * 16 + int'(wall_x)];

   always @(negedge clk) begin
      if (move === 1'b1) begin
         move_hi++;
         if (!move_prev) begin
            move_pulses++;
            win_at_move = win;
         end
      end
      move_prev = (move === 1'b1);
   end

   task automatic press(input logic [3:0] b);
      {btn_up, btn_down, btn_left, btn_right} = b;
      repeat (14) @(negedge clk);
      {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (pos_x !== 4'd0 || pos_y !== 4'd0) begin bad++; $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
      total++; if (wall_x !== 4'd0 || wall_y !== 4'd0) begin bad++; $display("FAIL reset_wall got=(%0d,%0d) exp=(0,0)", wall_x, wall_y); end
      total++; if (move !== 1'b0 || win !== 1'b0) begin bad++; $display("FAIL reset_move_win got=%b%b exp=00", move, win); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_hold_right();
      m0 = move_pulses;
      btn_right = 1'b1;
      repeat (20) @(negedge clk);
      btn_right = 1'b0;
      repeat (10) @(negedge clk);
      total++; if (move_pulses - m0 != 1) begin bad++; $display("FAIL hold_pulses got=%0d exp=1", move_pulses - m0); end
      total++; if (move_hi != move_pulses) begin bad++; $display("FAIL hold_width got=%0d exp=%0d", move_hi, move_pulses); end
      total++; if (pos_x !== 4'd1 || pos_y !== 4'd0) begin bad++; $display("FAIL hold_pos got=(%0d,%0d) exp=(1,0)", pos_x, pos_y); end
      total++; if (wall_x !== 4'd1 || wall_y !== 4'd0) begin bad++; $display("FAIL hold_addr got=(%0d,%0d) exp=(1,0)", wall_x, wall_y); end
   endtask

   task automatic test_glitch();
      m0 = move_pulses;
      btn_right = 1'b1;
      repeat (3) @(negedge clk);
      btn_right = 1'b0;
      repeat (15) @(negedge clk);
      total++; if (move_pulses != m0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", move_pulses - m0); end
      total++; if (pos_x !== 4'd1 || pos_y !== 4'd0) begin bad++; $display("FAIL glitch_pos got=(%0d,%0d) exp=(1,0)", pos_x, pos_y); end
   endtask

   task automatic test_bounds();
      do_reset();
      m0 = move_pulses;
      press(4'b1000);
      press(4'b0010);
      total++; if (move_pulses != m0) begin bad++; $display("FAIL bounds_pulses got=%0d exp=0", move_pulses - m0); end
      total++; if (pos_x !== 4'd0 || pos_y !== 4'd0) begin bad++; $display("FAIL bounds_pos got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
      total++; if (wall_x !== 4'd0 || wall_y !== 4'd0) begin bad++; $display("FAIL bounds_addr got=(%0d,%0d) exp=(0,0)", wall_x, wall_y); end
   endtask

   task automatic test_wall();
      press(4'b0001);
      wall_map[1 * 16 + 1] = 1'b1;
      m0 = move_pulses;
      press(4'b0100);
      total++; if (wall_x !== 4'd1 || wall_y !== 4'd1) begin bad++; $display("FAIL wall_addr got=(%0d,%0d) exp=(1,1)", wall_x, wall_y); end
      total++; if (pos_x !== 4'd1 || pos_y !== 4'd0) begin bad++; $display("FAIL wall_pos got=(%0d,%0d) exp=(1,0)", pos_x, pos_y); end
      total++; if (move_pulses != m0) begin bad++; $display("FAIL wall_pulses got=%0d exp=0", move_pulses - m0); end
      wall_map[1 * 16 + 1] = 1'b0;
      press(4'b0100);
      total++; if (pos_x !== 4'd1 || pos_y !== 4'd1) begin bad++; $display("FAIL clear_pos got=(%0d,%0d) exp=(1,1)", pos_x, pos_y); end
      total++; if (move_pulses - m0 != 1) begin bad++; $display("FAIL clear_pulses got=%0d exp=1", move_pulses - m0); end
   endtask

   task automatic test_priority();
      m0 = move_pulses;
      press(4'b1001);
      total++; if (pos_x !== 4'd1 || pos_y !== 4'd0) begin bad++; $display("FAIL prio_pos got=(%0d,%0d) exp=(1,0)", pos_x, pos_y); end
      total++; if (move_pulses - m0 != 1) begin bad++; $display("FAIL prio_pulses got=%0d exp=1", move_pulses - m0); end
   endtask

   task automatic test_reset_abort();
      int n;
      m0 = move_pulses;
      btn_right = 1'b1;
      n = 0;
      while (wall_x !== 4'd2 && n < 30) begin
         @(negedge clk);
         n++;
      end
      total++; if (wall_x !== 4'd2) begin bad++; $display("FAIL abort_lookup got=%0d exp=2", wall_x); end
      rst = 1'b0;
      btn_right = 1'b0;
      #1;
      total++; if (pos_x !== 4'd0 || pos_y !== 4'd0 || wall_x !== 4'd0) begin bad++; $display("FAIL abort_pos got=(%0d,%0d) addr_x=%0d exp=(0,0) 0", pos_x, pos_y, wall_x); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      total++; if (move_pulses != m0) begin bad++; $display("FAIL abort_pulses got=%0d exp=0", move_pulses - m0); end
   endtask

   task automatic test_win();
      for (int i = 0; i < 14; i++) press(4'b0001);
      for (int i = 0; i < 11; i++) press(4'b0100);
      total++; if (pos_x !== 4'd14 || pos_y !== 4'd11 || win !== 1'b0) begin bad++; $display("FAIL walk_pos got=(%0d,%0d) win=%b exp=(14,11) 0", pos_x, pos_y, win); end
      m0 = move_pulses;
      press(4'b0001);
      total++; if (pos_x !== 4'd15 || pos_y !== 4'd11) begin bad++; $display("FAIL win_pos got=(%0d,%0d) exp=(15,11)", pos_x, pos_y); end
      total++; if (win !== 1'b1 || win_at_move !== 1'b1) begin bad++; $display("FAIL win_level got=%b at_move=%b exp=1 1", win, win_at_move); end
      total++; if (move_pulses - m0 != 1) begin bad++; $display("FAIL win_pulses got=%0d exp=1", move_pulses - m0); end
      m0 = move_pulses;
      press(4'b0010);
      press(4'b1000);
      total++; if (move_pulses != m0 || pos_x !== 4'd15 || pos_y !== 4'd11 || win !== 1'b1) begin bad++; $display("FAIL won_absorb got=pulses %0d pos (%0d,%0d) win %b exp=0 (15,11) 1", move_pulses - m0, pos_x, pos_y, win); end
      btn_left = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++; if (pos_x !== 4'd0 || pos_y !== 4'd0 || win !== 1'b0 || move !== 1'b0) begin bad++; $display("FAIL win_reset got=(%0d,%0d) win=%b move=%b exp=(0,0) 0 0", pos_x, pos_y, win, move); end
      btn_left = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_hold_right();
      test_glitch();
      test_bounds();
      test_wall();
      test_priority();
      test_reset_abort();
      test_win();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/maze_move_ctrl.md
# maze_move_ctrl

Player-movement front end for the maze game. It debounces the four direction buttons and checks each requested step against the maze wall map through a synchronous-read port. It then updates the player position and emits the `move` pulse and `win` level consumed directly by the score/display stage. Position outputs also feed the VGA renderer.

## Interface
- `GRID_W`, 16, maze width in cells (x range 0..GRID_W-1)
- `GRID_H`, 12, maze height in cells (y range 0..GRID_H-1)
- `POS_W`, 4, width of x/y coordinates; must hold max(GRID_W, GRID_H)-1
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable samples required to accept a button level change (10 ms at 100 MHz)
- `START_X`, `START_Y`, 0, 0, player cell after reset
- `GOAL_X`, `GOAL_Y`, 15, 11, goal cell; must differ from start
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw asynchronous push-buttons, active-high
- `wall_x`  out  POS_W  maze-map read address, column
- `wall_y`  out  POS_W  maze-map read address, row
- `wall_hit`  in  1  map data: 1 = cell at previous cycle's (`wall_x`,`wall_y`) is a wall (1-cycle read latency)
- `pos_x`, `pos_y`  out  POS_W each  current player cell
- `move`  out  1  one-cycle pulse per accepted step
- `win`  out  1  high from the step that reaches the goal until reset

## Operation
- Per button: 2-flop synchronizer, then debounce counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it. Any matching sample clears the counter.
- Press event = 0->1 transition of a debounced level; lasts one cycle. Releases generate nothing.
- Same-cycle events are resolved by priority up > down > left > right. Lower-priority events are discarded, not queued.
- Direction math: up = y-1, down = y+1, left = x-1, right = x+1.
- FSM states: IDLE, LOOKUP, CHECK, WON.
- IDLE: on a press event, compute the target cell.
  - If the target is outside the grid (x or y would go below 0, or x ≥ GRID_W, or y ≥ GRID_H), the event is rejected. The block stays in IDLE with no lookup and no `move`.
  - Otherwise, register the target onto `wall_x`/`wall_y` and go to LOOKUP.
- LOOKUP: hold the address for one cycle; the map registers its data. Then go to CHECK.
- CHECK: sample `wall_hit`.
  - If 1: discard the target and return to IDLE.
  - If 0: on this edge, load `pos_x`/`pos_y` with the target and set `move`=1.
  - If 0 and the target equals the goal: also set `win`=1 and go to WON. Otherwise return to IDLE.
- WON: absorbing until reset. All press events are ignored, and `move` stays 0.
- Press events arriving outside IDLE are dropped.
- Debouncers keep running in every state, so a held button never produces a repeat event.
- Coordinates are unsigned POS_W bits. Bounds checks use the current position before arithmetic, so no wrap-around can occur.

## Timing
- Reset values (async, immediate): `pos_x`=START_X, `pos_y`=START_Y, `wall_x`=START_X, `wall_y`=START_Y, `move`=0, `win`=0, state IDLE, debounced levels 0, counters 0, synchronizers 0.
- Button to press event: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Press event seen in IDLE at edge k:
  - state is LOOKUP and address is valid after edge k;
  - state is CHECK after edge k+1;
  - `pos`/`move`/`win` update at edge k+2.
- `move` is high exactly one cycle, from edge k+2 to edge k+3.
- Minimum spacing between accepted steps: 3 cycles (far below the debounce time in practice).
- `win` rises on the same edge as the final `move` pulse.
- Reset asserted mid-lookup aborts the step. Position returns to start, and no `move` is emitted.
- Reset release: the first press event can occur no earlier than DEBOUNCE_CYCLES+3 cycles later.

## Test plan
(All scenarios run with DEBOUNCE_CYCLES=4 and the map model returning `wall_hit` one cycle after the address.)

- Reset at start (0,0), `btn_right` held 20 cycles, no wall: one `move` pulse, `pos`=(1,0), `wall_x`/`wall_y`=(1,0) during LOOKUP, no second pulse while held.
- `btn_right` glitch high for 3 cycles: no press event, `pos` unchanged, `move` never asserts.
- At (0,0), press up then left: both rejected at the bounds check, no LOOKUP entered, `pos`=(0,0), `move`=0.
- At (1,0), wall at (1,1), press down: lookup addresses (1,1), `wall_hit`=1, `pos` stays (1,0), no `move`.
- `btn_up` and `btn_right` debounced on the same cycle at (1,1) with no walls: only up is executed, giving `pos`=(1,0) and exactly one `move`.
- Player at (14,11), press right: `pos`=(15,11), `move` and `win` rise on the same edge, further presses ignored. Then pull `rst`=0 mid-hold: `pos`=(0,0), `win`=0 immediately.
